// File: rtl/sram_seq_pkg.sv
// Shared types and SRAM memory-map constants for the image-decode phase sequencer.
package sram_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_UART   = 3'd1,
        S_M2_GO  = 3'd2,
        S_M2_RUN = 3'd3,
        S_M1_GO  = 3'd4,
        S_M1_RUN = 3'd5,
        S_DONE   = 3'd6,
        S_ERROR  = 3'd7
    } seq_state_type;

    typedef enum logic [2:0] {
        OWN_NONE = 3'd0,
        OWN_UART = 3'd1,
        OWN_M1   = 3'd2,
        OWN_M2   = 3'd3,
        OWN_VGA  = 3'd4
    } sram_owner_type;

    // Segment bases shared with M1/M2 address generators.
    localparam logic [17:0] Y_SEGMENT_BASE        = 18'd0;
    localparam logic [17:0] U_SEGMENT_BASE        = 18'd38400;
    localparam logic [17:0] V_SEGMENT_BASE        = 18'd57600;
    localparam logic [17:0] PRE_IDCT_SEGMENT_BASE = 18'd76800;
    localparam logic [17:0] RGB_SEGMENT_BASE      = 18'd146944;

    function automatic sram_owner_type owner_of(input seq_state_type s);
        case (s)
            S_UART:            return OWN_UART;
            S_M2_GO, S_M2_RUN: return OWN_M2;
            S_M1_GO, S_M1_RUN: return OWN_M1;
            S_DONE:            return OWN_VGA;
            default:           return OWN_NONE;
        endcase
    endfunction

endpackage

// File: rtl/sram_phase_sequencer_watchdog.sv
// Per-phase watchdog: clearable, saturating cycle counter flagging PHASE_TIMEOUT-1.
module phase_watchdog #(
    parameter int unsigned            TIMEOUT_W     = 26,
    parameter logic [TIMEOUT_W-1:0]   PHASE_TIMEOUT = 26'd50_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TIMEOUT_W-1:0] LIMIT =
        PHASE_TIMEOUT - {{(TIMEOUT_W-1){1'b0}}, 1'b1};

    logic [TIMEOUT_W-1:0] count;

    assign expired = (count == LIMIT);

    // Holds at LIMIT so a stalled phase keeps reporting expiry instead of wrapping.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/sram_phase_sequencer.sv
// Phase scheduler for UART -> M2 -> M1 -> VGA; owns the single SRAM port.
module sram_phase_sequencer
    import sram_seq_pkg::*;
#(
    parameter int unsigned          ADDR_W        = 18,
    parameter int unsigned          DATA_W        = 16,
    parameter int unsigned          TIMEOUT_W     = 26,
    parameter logic [TIMEOUT_W-1:0] PHASE_TIMEOUT = 26'd50_000_000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              uart_done,
    input  logic [ADDR_W-1:0] uart_addr,
    input  logic [DATA_W-1:0] uart_wdata,
    input  logic              uart_we_n,
    output logic              enable_M1,
    output logic              enable_M2,
    input  logic              stop_M1,
    input  logic              stop_M2,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic              m1_we_n,
    input  logic [ADDR_W-1:0] m2_addr,
    input  logic [DATA_W-1:0] m2_wdata,
    input  logic              m2_we_n,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic [ADDR_W-1:0] SRAM_address,
    output logic [DATA_W-1:0] SRAM_write_data,
    output logic              SRAM_we_n,
    output logic [2:0]        phase,
    output logic              busy,
    output logic              done,
    output logic              error
);

    seq_state_type  state, next_state;
    sram_owner_type owner;
    logic           wd_clear, wd_enable, wd_expired;

    assign wd_clear  = (next_state != state);
    assign wd_enable = (state == S_UART) || (state == S_M2_RUN) || (state == S_M1_RUN);

    phase_watchdog #(
        .TIMEOUT_W     (TIMEOUT_W),
        .PHASE_TIMEOUT (PHASE_TIMEOUT)
    ) u_watchdog (
        .clock   (clock),
        .reset   (reset),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    // Exit conditions are tested before the watchdog so a coincident finish wins.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (start) next_state = S_UART;
            S_UART: begin
                if (uart_done)       next_state = S_M2_GO;
                else if (wd_expired) next_state = S_ERROR;
            end
            S_M2_GO:  next_state = S_M2_RUN;
            S_M2_RUN: begin
                if (stop_M2)         next_state = S_M1_GO;
                else if (wd_expired) next_state = S_ERROR;
            end
            S_M1_GO:  next_state = S_M1_RUN;
            S_M1_RUN: begin
                if (stop_M1)         next_state = S_DONE;
                else if (wd_expired) next_state = S_ERROR;
            end
            S_DONE:   if (start) next_state = S_UART;
            S_ERROR:  if (start) next_state = S_UART;
            default:  next_state = S_IDLE;
        endcase
    end

    // Owner and status outputs load from next_state so they align with the state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            owner     <= OWN_NONE;
            enable_M1 <= 1'b0;
            enable_M2 <= 1'b0;
            phase     <= 3'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            state     <= next_state;
            owner     <= owner_of(next_state);
            enable_M1 <= (next_state == S_M1_GO);
            enable_M2 <= (next_state == S_M2_GO);
            phase     <= next_state;
            busy      <= (next_state == S_UART)   || (next_state == S_M2_GO) ||
                         (next_state == S_M2_RUN) || (next_state == S_M1_GO) ||
                         (next_state == S_M1_RUN);
            done      <= (next_state == S_DONE);
            error     <= (next_state == S_ERROR);
        end
    end

    always_comb begin
        SRAM_address    = '0;
        SRAM_write_data = '0;
        SRAM_we_n       = 1'b1;
        case (owner)
            OWN_UART: begin
                SRAM_address    = uart_addr;
                SRAM_write_data = uart_wdata;
                SRAM_we_n       = uart_we_n;
            end
            OWN_M2: begin
                SRAM_address    = m2_addr;
                SRAM_write_data = m2_wdata;
                SRAM_we_n       = m2_we_n;
            end
            OWN_M1: begin
                SRAM_address    = m1_addr;
                SRAM_write_data = m1_wdata;
                SRAM_we_n       = m1_we_n;
            end
            OWN_VGA: begin
                SRAM_address    = vga_addr;
            end
            default: ;
        endcase
    end

endmodule
